ov5640_axis_bridge: RTL
=======================

// Module: ov5640_axis_bridge
// PURPOSE
//  Downstream stage of the OV5640 capture/demosaic path. Converts the 24-bit RGB
//  pixel bus with out_vsync/out_hsync/out_active qualifiers into an AXI4-Stream
//  video master (tuser = SOF, tlast = EOL) for the VDMA.
//  A small FIFO absorbs tready backpressure, because the camera side cannot stall.
//  Overflow drops the rest of the frame and resynchronises on the next vsync.
// PARAMETERS
//  VIDEO_WIDTH   1280  active pixels per line; forces tlast when the column counter hits VIDEO_WIDTH-1
//  DATA_WIDTH    24    pixel width (3 x 8-bit channels)
//  FIFO_DEPTH    16    FIFO entries; power of 2, >= 4
// PORTS
//  clk            in   1              pixel clock, single clock domain
//  rst            in   1              synchronous, active-low reset
//  in_data        in   DATA_WIDTH     RGB pixel, valid when in_active=1
//  in_vsync       in   1              frame sync, active high during vertical blanking
//  in_hsync       in   1              line qualifier (ignored except as documentation; in_active is used)
//  in_active      in   1              pixel valid strobe
//  m_axis_tdata   out  DATA_WIDTH     pixel
//  m_axis_tvalid  out  1              beat valid
//  m_axis_tready  in   1              sink ready
//  m_axis_tuser   out  1              1 on first beat of frame
//  m_axis_tlast   out  1              1 on last beat of line
//  out_overflow   out  1              sticky: FIFO overflow since reset
//  out_fifo_level out  clog2(DEPTH)+1 current FIFO occupancy
// BEHAVIOUR
//  Reset (rst=0 at posedge clk): tvalid, tuser, tlast, out_overflow = 0; FIFO emptied; column = 0;
//   sof_pending = 0; drop = 0; hold_valid = 0; tdata holds its value (don't care).
//  Reset mid-frame: no partial beat is emitted afterwards. Stream restarts at the next vsync rising edge.
//  SOF: a rising edge of in_vsync (registered compare) sets sof_pending=1, clears drop and column.
//   The first accepted pixel after that edge carries tuser=1 and clears sof_pending.
//   Pixels arriving while no vsync edge has been seen since reset are discarded.
//  Hold stage: each pixel is registered in a 1-entry hold reg (data, sof flag).
//   The held pixel is written to the FIFO on the next cycle with
//   tlast = (in_active==0) | (column==VIDEO_WIDTH-1) | vsync_rise.
//   Short lines therefore still end with tlast. Column wraps to 0 after each tlast.
//  Back-to-back pixels: one FIFO write per cycle max, no bubbles inserted.
//  FIFO write allowed when level < FIFO_DEPTH, or when level == FIFO_DEPTH and a read occurs in the same cycle.
//   Otherwise the write is dropped, out_overflow=1 (sticky until reset), and drop=1.
//   While drop=1, all pixels are discarded until the next vsync rising edge.
//  Output: FIFO head is presented registered. tvalid stays high until tvalid&tready.
//   tdata/tuser/tlast are stable while tvalid&!tready (AXI rule).
//  Latency: in_active pixel -> m_axis_tvalid is 3 cycles when FIFO empty and tready=1 (hold, FIFO, out reg).
//  Throughput: 1 beat/cycle with sustained tready.
//  Level: increments on write, decrements on read, unchanged on simultaneous write+read.
//  Simultaneous vsync rise + held pixel: the held pixel is flushed with tlast=1, then SOF is armed.
//   The new frame's first pixel gets tuser, never the flushed one.
// STRUCTURE
//  ov5640_defs.vh: VIDEO_WIDTH/DATA_WIDTH defaults, clog2 macro; shared with ov5640 top.
//  Sub-module axis_fifo_sync (DATA_WIDTH+2 wide: {tuser,tlast,data}, FIFO_DEPTH, show-ahead, level port).
//  Bridge = vsync edge detect, column counter, hold reg, drop FSM (IDLE->RUN on vsync rise;
//   RUN->DROP on overflow; DROP->RUN on vsync rise), output register.
// TESTING
//  1 frame 4x3 (VIDEO_WIDTH=4), tready=1 -> 12 beats; tuser only on beat 0; tlast on beats 3,7,11; data in order.
//  Short line of 2 pixels, then in_active low -> tlast on 2nd beat; column restarts at 0 for the next line.
//  tready toggled 1010... over a 4x3 frame -> all 12 beats delivered; tdata/tuser/tlast stable while stalled; no overflow.
//  tready=0 for a full 1280 line, FIFO_DEPTH=16 -> 16 beats stored, out_overflow=1; no beats until next vsync;
//   next frame's first beat has tuser=1.
//  Pixels before the first vsync rise after reset -> no beats emitted.
//  rst=0 mid-line with tvalid=1 -> next cycle tvalid=0, level=0, out_overflow=0; output resumes with tuser=1 after a vsync rise.

Source files
------------

// File: rtl/ov5640_axis_bridge_pkg.sv
// Shared types and helpers for the OV5640 RGB-to-AXI4-Stream bridge.
package ov5640_axis_bridge_pkg;

  // Frame acceptance state: waiting for the first vsync, streaming, or
  // discarding the remainder of a frame after an overflow.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DROP = 2'd2
  } drop_state_e;

  // Counter width helper that never returns zero.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/ov5640_axis_bridge_fifo.sv
// Synchronous show-ahead FIFO with an occupancy output.
// The caller guarantees wr_en_i only when there is room (or a read happens
// in the same cycle) and rd_en_i only when the FIFO is not empty.
module ov5640_axis_bridge_fifo #(
  parameter int W     = 26,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [W-1:0]           wr_data_i,
  input  logic                   rd_en_i,
  output logic [W-1:0]           rd_data_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  // Pointer and occupancy next-state; simultaneous write+read keeps the level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en_i) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en_i && !rd_en_i) level_d = level_q + (AW+1)'(1);
    if (!wr_en_i && rd_en_i) level_d = level_q - (AW+1)'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;

endmodule

// File: rtl/ov5640_axis_bridge.sv
// OV5640 RGB pixel bus to AXI4-Stream video master (tuser = SOF, tlast = EOL).
// Path: vsync edge detect -> hold register -> FIFO -> output register.
// Handshake: a beat transfers on a rising clk edge where m_axis_tvalid and
// m_axis_tready are both 1; once tvalid rises, tvalid/tdata/tuser/tlast stay
// unchanged until that transfer. The camera side has no backpressure.
module ov5640_axis_bridge
  import ov5640_axis_bridge_pkg::*;
#(
  parameter int VIDEO_WIDTH = 1280,
  parameter int DATA_WIDTH  = 24,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_vsync,
  input  logic                        in_hsync,
  input  logic                        in_active,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic                        out_overflow,
  output logic [$clog2(FIFO_DEPTH):0] out_fifo_level,
  output logic [1:0]                  dbg_state_o
);
  localparam int COL_W = clog2_min1(VIDEO_WIDTH);
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int FW    = DATA_WIDTH + 2;

  drop_state_e           state_q, state_d;
  logic                  vsync_q;
  logic                  sof_pending_q, sof_pending_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  hold_sof_q, hold_sof_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic                  overflow_q, overflow_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tuser_q, tuser_d;
  logic                  tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;

  logic                  vsync_rise, wr_last, room, ovf_now, take;
  logic                  fifo_wr, fifo_rd, fifo_empty;
  logic [FW-1:0]         fifo_rdata;
  logic [LW-1:0]         fifo_level;
  logic                  hsync_unused;

  // in_active alone qualifies pixels; hsync is carried for documentation only.
  assign hsync_unused = in_hsync;

  assign vsync_rise = in_vsync & ~vsync_q;
  assign fifo_rd    = ~fifo_empty & (~tvalid_q | m_axis_tready);
  assign room       = (fifo_level < LW'(FIFO_DEPTH)) | fifo_rd;
  // The held pixel closes its line when the stream pauses, the line is full,
  // or a new frame begins.
  assign wr_last    = ~in_active | (col_q == COL_W'(VIDEO_WIDTH - 1)) | vsync_rise;
  assign fifo_wr    = hold_valid_q & room;
  assign ovf_now    = hold_valid_q & ~room;
  assign take       = in_active & (vsync_rise | ((state_q == ST_RUN) & ~ovf_now));

  // Drop FSM: a vsync rise always (re)starts streaming, even on overflow.
  always_comb begin
    state_d = state_q;
    if (vsync_rise)                          state_d = ST_RUN;
    else if (state_q == ST_RUN && ovf_now)   state_d = ST_DROP;
  end

  // Hold stage, SOF arming, column counter and sticky overflow.
  always_comb begin
    sof_pending_d = sof_pending_q;
    hold_valid_d  = take;
    hold_sof_d    = hold_sof_q;
    hold_data_d   = hold_data_q;
    col_d         = col_q;
    overflow_d    = overflow_q | ovf_now;
    if (take) begin
      hold_sof_d    = sof_pending_q | vsync_rise;
      hold_data_d   = in_data;
      sof_pending_d = 1'b0;
    end else if (vsync_rise) begin
      sof_pending_d = 1'b1;
    end
    if (fifo_wr) col_d = wr_last ? '0 : col_q + COL_W'(1);
    if (vsync_rise) col_d = '0;
  end

  // Output register loads the FIFO head whenever it is empty or being drained.
  always_comb begin
    tvalid_d = tvalid_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    if (fifo_rd) begin
      tvalid_d                     = 1'b1;
      {tuser_d, tlast_d, tdata_d}  = fifo_rdata;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    vsync_q <= in_vsync;
    if (!rst) begin
      state_q       <= ST_IDLE;
      sof_pending_q <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_sof_q    <= 1'b0;
      col_q         <= '0;
      overflow_q    <= 1'b0;
      tvalid_q      <= 1'b0;
      tuser_q       <= 1'b0;
      tlast_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sof_pending_q <= sof_pending_d;
      hold_valid_q  <= hold_valid_d;
      hold_sof_q    <= hold_sof_d;
      col_q         <= col_d;
      overflow_q    <= overflow_d;
      tvalid_q      <= tvalid_d;
      tuser_q       <= tuser_d;
      tlast_q       <= tlast_d;
    end
  end

  // Pixel data registers; their value is irrelevant while not valid.
  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
    tdata_q     <= tdata_d;
  end

  ov5640_axis_bridge_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i ({hold_sof_q, wr_last, hold_data_q}),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign m_axis_tdata   = tdata_q;
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tuser   = tuser_q;
  assign m_axis_tlast   = tlast_q;
  assign out_overflow   = overflow_q;
  assign out_fifo_level = fifo_level;
  assign dbg_state_o    = state_q;

endmodule
